// File: rtl/adc_frame_packer.sv
// Snapshots NUM_CH ADC words on a decimated strobe and streams them as a
// framed byte sequence: HEADER, sequence, channel bytes, XOR checksum.
module adc_frame_packer #(
  parameter int         NUM_CH       = 2,
  parameter int         IN_WIDTH     = 16,
  parameter int         SAMPLE_BYTES = 1,
  parameter int         DECIM_W      = 8,
  parameter logic [7:0] HEADER       = 8'hA5
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic [NUM_CH*IN_WIDTH-1:0] i_samples,
  input  logic                       i_sample_valid,
  input  logic [DECIM_W-1:0]         i_decim,
  input  logic                       i_mode,
  output logic [7:0]                 o_byte,
  output logic                       o_byte_valid,
  input  logic                       i_byte_ready,
  output logic                       o_frame_busy,
  output logic [7:0]                 o_overrun_count,
  output logic [2:0]                 o_fsm_state
);

  localparam int NB    = NUM_CH * SAMPLE_BYTES;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_SEQ  = 3'd2,
    S_DATA = 3'd3,
    S_CSUM = 3'd4
  } state_t;

  state_t             state, state_nxt;
  logic [DECIM_W-1:0] dec_cnt;
  logic [7:0]         seq;
  logic [7:0]         csum;
  logic [IDX_W-1:0]   idx;
  logic [7:0]         snap [NB];
  logic [7:0]         pick [NB];
  logic               candidate;
  logic               capture;
  logic               hs;
  logic               unused_lsbs;

  // Stream handshake: a byte transfers on a clock edge where o_byte_valid and
  // i_byte_ready are both high; o_byte_valid depends only on state, so the
  // byte is held stable until accepted.
  assign candidate   = i_sample_valid && (dec_cnt == '0);
  assign capture     = candidate && (state == S_IDLE);
  assign hs          = o_byte_valid && i_byte_ready;
  assign unused_lsbs = ^i_samples;

  // Emission order: ch0 first, MSB byte first within each channel.
  always_comb begin
    pick = '{default: 8'h00};
    for (int ch = 0; ch < NUM_CH; ch++) begin
      for (int k = 0; k < SAMPLE_BYTES; k++) begin
        pick[ch*SAMPLE_BYTES+k] = i_samples[ch*IN_WIDTH + IN_WIDTH-1-8*k -: 8];
      end
      pick[ch*SAMPLE_BYTES][7] = pick[ch*SAMPLE_BYTES][7] ^ i_mode;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    o_byte       = 8'h00;
    o_byte_valid = 1'b0;
    case (state)
      S_IDLE: if (capture) state_nxt = S_HDR;
      S_HDR: begin
        o_byte       = HEADER;
        o_byte_valid = 1'b1;
        if (i_byte_ready) state_nxt = S_SEQ;
      end
      S_SEQ: begin
        o_byte       = seq;
        o_byte_valid = 1'b1;
        if (i_byte_ready) state_nxt = S_DATA;
      end
      S_DATA: begin
        o_byte       = snap[idx];
        o_byte_valid = 1'b1;
        if (i_byte_ready && (idx == LAST_IDX)) state_nxt = S_CSUM;
      end
      S_CSUM: begin
        o_byte       = csum;
        o_byte_valid = 1'b1;
        if (i_byte_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      dec_cnt <= '0;
      seq     <= 8'h00;
      csum    <= 8'h00;
      idx     <= '0;
      for (int i = 0; i < NB; i++) snap[i] <= 8'h00;
    end else begin
      if (i_sample_valid) begin
        dec_cnt <= (dec_cnt == '0) ? i_decim : dec_cnt - 1'b1;
      end
      if (capture) begin
        snap <= pick;
        csum <= 8'h00;
        idx  <= '0;
      end
      if (hs) begin
        case (state)
          S_HDR, S_SEQ: csum <= csum ^ o_byte;
          S_DATA: begin
            csum <= csum ^ o_byte;
            idx  <= idx + 1'b1;
          end
          S_CSUM: begin
            seq <= seq + 8'd1;
            idx <= '0;
          end
          default: ;
        endcase
      end
    end
  end

  // A candidate arriving while a frame is still being sent is lost.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      o_overrun_count <= 8'h00;
    end else if (candidate && (state != S_IDLE) && (o_overrun_count != 8'hFF)) begin
      o_overrun_count <= o_overrun_count + 8'd1;
    end
  end

  assign o_frame_busy = (state != S_IDLE);
  assign o_fsm_state  = state;

endmodule

// File: tb/tb_adc_frame_packer.sv
// Directed bench for adc_frame_packer (NUM_CH=2, SAMPLE_BYTES=1): framing,
// backpressure, overrun saturation, decimation, async reset and sequence wrap.
module tb_adc_frame_packer;

  logic        i_clock = 1'b0;
  logic        i_reset;
  logic [31:0] i_samples;
  logic        i_sample_valid;
  logic [7:0]  i_decim;
  logic        i_mode;
  logic [7:0]  o_byte;
  logic        o_byte_valid;
  logic        i_byte_ready;
  logic        o_frame_busy;
  logic [7:0]  o_overrun_count;
  logic [2:0]  fsm_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q [$];

  adc_frame_packer dut (
    .i_clock         (i_clock),
    .i_reset         (i_reset),
    .i_samples       (i_samples),
    .i_sample_valid  (i_sample_valid),
    .i_decim         (i_decim),
    .i_mode          (i_mode),
    .o_byte          (o_byte),
    .o_byte_valid    (o_byte_valid),
    .i_byte_ready    (i_byte_ready),
    .o_frame_busy    (o_frame_busy),
    .o_overrun_count (o_overrun_count),
    .o_fsm_state     (fsm_state)
  );

  always #5 i_clock = ~i_clock;

  task automatic tick();
    @(negedge i_clock);
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic reset_dut();
    i_reset = 1'b0;
    tick();
    i_reset = 1'b1;
    tick();
  endtask

  // Strobe one sample; returns at the negedge after the capture edge.
  task automatic send_strobe(input logic [31:0] s, input logic m);
    i_samples      = s;
    i_mode         = m;
    i_sample_valid = 1'b1;
    tick();
    i_sample_valid = 1'b0;
  endtask

  // Expects a frame to be presented now. hold: cycles of ready low on the
  // header (flooding strobes if flood); ovr_at: byte index that gets a junk strobe.
  task automatic expect_frame(input logic [7:0] seq, input logic [7:0] d0,
                              input logic [7:0] d1, input logic [7:0] cs,
                              input int hold, input int ovr_at, input logic flood);
    logic [7:0] e;
    exp_q.push_back(8'hA5);
    exp_q.push_back(seq);
    exp_q.push_back(d0);
    exp_q.push_back(d1);
    exp_q.push_back(cs);
    for (int h = 0; h < hold; h++) begin
      check("bp_valid", o_byte_valid, 1'b1);
      check("bp_byte", o_byte, 8'hA5);
      i_byte_ready   = 1'b0;
      i_sample_valid = flood;
      tick();
    end
    for (int b = 0; b < 5; b++) begin
      e = exp_q.pop_front();
      check("byte_valid", o_byte_valid, 1'b1);
      check($sformatf("byte%0d", b), o_byte, e);
      i_byte_ready   = 1'b1;
      i_sample_valid = (b == ovr_at);
      if (b == ovr_at) i_samples = 32'h0000_0000;
      tick();
    end
    i_sample_valid = 1'b0;
    check("busy_fall", o_frame_busy, 1'b0);
    check("valid_fall", o_byte_valid, 1'b0);
  endtask

  initial begin
    i_reset        = 1'b0;
    i_samples      = 32'h0;
    i_sample_valid = 1'b0;
    i_decim        = 8'd0;
    i_mode         = 1'b0;
    i_byte_ready   = 1'b1;
    tick();
    tick();
    check("rst_valid", o_byte_valid, 1'b0);
    check("rst_byte", o_byte, 8'h00);
    check("rst_busy", o_frame_busy, 1'b0);
    check("rst_ovr", o_overrun_count, 8'h00);
    check("rst_state", fsm_state, 3'd0);
    i_reset = 1'b1;
    tick();

    // Offset binary
    send_strobe(32'h8100_7F00, 1'b1);
    expect_frame(8'h00, 8'hFF, 8'h01, 8'h5B, 0, -1, 1'b0);

    // Raw mode, then the same data with the next sequence number
    reset_dut();
    send_strobe(32'hFF00_0000, 1'b0);
    expect_frame(8'h00, 8'h00, 8'hFF, 8'h5A, 0, -1, 1'b0);
    send_strobe(32'hFF00_0000, 1'b0);
    expect_frame(8'h01, 8'h00, 8'hFF, 8'h5B, 0, -1, 1'b0);

    // Backpressure on the header for 5 cycles
    send_strobe(32'h1234_5678, 1'b0);
    expect_frame(8'h02, 8'h56, 8'h12, 8'hE3, 5, -1, 1'b0);
    check("bp_no_ovr", o_overrun_count, 8'h00);

    // Overrun during DATA, then 300 drops saturating the counter
    reset_dut();
    send_strobe(32'hC3C3_3C3C, 1'b1);
    expect_frame(8'h00, 8'hBC, 8'h43, 8'h5A, 0, 2, 1'b0);
    check("ovr_one", o_overrun_count, 8'h01);
    send_strobe(32'hC3C3_3C3C, 1'b1);
    expect_frame(8'h01, 8'hBC, 8'h43, 8'h5B, 300, -1, 1'b1);
    check("ovr_sat", o_overrun_count, 8'hFF);

    // Decimation by 3: strobes 1 and 4 make frames
    reset_dut();
    i_decim = 8'd2;
    for (int s = 0; s < 6; s++) begin
      send_strobe({8'h10 + 8'(s), 8'h00, 8'h20 + 8'(s), 8'h00}, 1'b0);
      if (s == 0) expect_frame(8'h00, 8'h20, 8'h10, 8'h95, 0, -1, 1'b0);
      else if (s == 3) expect_frame(8'h01, 8'h23, 8'h13, 8'h94, 0, -1, 1'b0);
      else begin
        for (int c = 0; c < 8; c++) begin
          check("decim_skip", o_byte_valid, 1'b0);
          tick();
        end
      end
    end
    check("decim_ovr", o_overrun_count, 8'h00);
    i_decim = 8'd0;

    // Asynchronous reset while DATA is being presented
    send_strobe(32'h8100_7F00, 1'b1);
    check("pre_hdr", o_byte, 8'hA5);
    i_sample_valid = 1'b1;
    tick();
    i_sample_valid = 1'b0;
    tick();
    check("pre_data", o_byte, 8'hFF);
    check("pre_ovr", o_overrun_count, 8'h01);
    #2 i_reset = 1'b0;
    #1;
    check("arst_valid", o_byte_valid, 1'b0);
    check("arst_busy", o_frame_busy, 1'b0);
    check("arst_ovr", o_overrun_count, 8'h00);
    tick();
    i_reset = 1'b1;
    tick();
    check("post_ovr", o_overrun_count, 8'h00);
    send_strobe(32'h8100_7F00, 1'b1);
    expect_frame(8'h00, 8'hFF, 8'h01, 8'h5B, 0, -1, 1'b0);

    // Frames 2..257 after reset; the 257th wraps back to sequence 00
    for (int n = 1; n <= 256; n++) begin
      send_strobe({8'(n), 8'h00, ~8'(n), 8'h00}, 1'b0);
      expect_frame(8'(n), ~8'(n), 8'(n), 8'h5A ^ 8'(n), 0, -1, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_frame_packer.md
Name: adc_frame_packer

Overview:
- Parametrised successor to the fixed two-channel 8-MSB offset-binary converter that feeds tx_unit.
- Snapshots NUM_CH ADC channel words per decimated sample and optionally converts each to offset binary.
- Serialises each snapshot as a framed byte stream: header, sequence, data, XOR checksum.
- Sits between adc (o_data_out_ch*) and a byte-wide UART transmitter, using a valid/ready handshake.

Parameters:
- NUM_CH, 2, number of channels packed per frame (1..8).
- IN_WIDTH, 16, width of each input channel word.
- SAMPLE_BYTES, 1, bytes emitted per channel (1 or 2). Top 8*SAMPLE_BYTES bits of each word are used.
- DECIM_W, 8, width of decimation control.
- HEADER, 8'hA5, frame start byte.

Ports:
- i_clock  in  1  system clock (sys_clock domain).
- i_reset  in  1  asynchronous, active-low reset.
- i_samples  in  NUM_CH*IN_WIDTH  channel words; ch0 in bits [IN_WIDTH-1:0], ch1 next up.
- i_sample_valid  in  1  one-cycle strobe: i_samples valid this cycle.
- i_decim  in  DECIM_W  keep one sample in every (i_decim+1).
- i_mode  in  1  0 = raw truncated MSBs; 1 = offset binary (invert MSB of each truncated sample).
- o_byte  out  8  stream byte.
- o_byte_valid  out  1  o_byte valid.
- i_byte_ready  in  1  downstream accepts o_byte when high with o_byte_valid.
- o_frame_busy  out  1  frame in progress (state != IDLE).
- o_overrun_count  out  8  saturating count of dropped decimated samples.

Behaviour:
- Reset (i_reset low, asynchronous):
  - State IDLE; o_byte = 0; o_byte_valid = 0; o_frame_busy = 0; o_overrun_count = 0.
  - Sequence counter = 0; decimation counter = 0; snapshot registers = 0.
  - Takes effect immediately, including mid-frame. The partial frame is discarded, never resumed.
- Decimation, evaluated on each i_sample_valid:
  - dec_cnt == 0: sample is a candidate; dec_cnt <= i_decim.
  - Otherwise: dec_cnt <= dec_cnt - 1; sample ignored.
  - i_decim = 0 keeps every sample. i_decim is sampled only at reload.
- Capture:
  - Candidate in IDLE: latch truncated (and, if i_mode = 1, MSB-inverted) channel bytes. i_mode is sampled at capture.
  - Go to HDR next edge. o_byte_valid rises the cycle after the strobe (latency 1) with o_byte = HEADER.
  - Candidate while not IDLE: dropped, snapshot untouched; o_overrun_count += 1, saturating at 255.
- States:
  - IDLE: o_byte_valid = 0; waits for a candidate.
  - HDR: o_byte = HEADER.
  - SEQ: o_byte = sequence.
  - DATA: NUM_CH*SAMPLE_BYTES bytes, ch0 first, MSB byte first within a channel; byte index counter.
  - CSUM: o_byte = XOR of HEADER, sequence and all data bytes.
- Advance and sequencing:
  - Each state advances only on handshake (o_byte_valid & i_byte_ready) in the same cycle.
  - After the CSUM handshake: IDLE, sequence += 1 (wraps 255 -> 0).
  - A candidate in the same cycle as the CSUM handshake counts as overrun (state not yet IDLE).
- Stability and timing:
  - While o_byte_valid & !i_byte_ready, o_byte and state hold.
  - No combinational path from i_byte_ready to o_byte_valid.
  - Running checksum is accumulated registered, one XOR per handshake.
  - Back-to-back frames: at least one IDLE cycle between CSUM handshake and next HDR.
- Truncation: byte k of a channel = word[IN_WIDTH-1-8k -: 8]. Mode 1 inverts only bit 7 of byte 0 (the channel MSB).

Test Plan:
- Offset mode: NUM_CH=2, SAMPLE_BYTES=1, i_mode=1, i_decim=0, i_samples=32'h8100_7F00, one strobe, ready held high -> bytes A5,00,FF,01,5B on consecutive cycles; o_frame_busy falls after 5B.
- Raw mode: i_mode=0, i_samples=32'hFF00_0000 -> A5,00,00,FF,5A. Second frame uses sequence 01; checksum 5B with the same data.
- Backpressure: ready low 5 cycles while header shown -> o_byte stays A5 and valid stays high. Ready high -> sequence follows next cycle; frame bytes unchanged.
- Overrun: strobe during DATA -> o_overrun_count = 1 and current frame data unchanged. 300 such drops -> count stays 255.
- Decimation: i_decim=2, six strobes spaced beyond frame length -> exactly two frames from strobes 1 and 4, sequences 00 and 01.
- Reset mid-frame: assert i_reset low during DATA -> o_byte_valid = 0 within the same cycle (async). After release, next frame sequence = 00 and o_overrun_count = 0. Sequence wrap: 257 frames -> 257th carries 00.
